// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Entries carry the {pc, instr} pair handed over from the fetch unit.
package fq_pkg;

    localparam int          FQ_DEPTH = 4;
    localparam logic [31:0] FQ_NOP   = 32'h0;
    localparam int          FQ_PTR_W = $clog2(FQ_DEPTH);
    localparam int          FQ_CNT_W = $clog2(FQ_DEPTH + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for the fetch queue: synchronous write, asynchronous read.
// Contents are never cleared; the top only exposes entries it knows are valid.
module fetch_queue_mem
    import fq_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [PW-1:0] waddr_i,
    input  fq_entry_t     wdata_i,
    input  logic [PW-1:0] raddr_i,
    output fq_entry_t     rdata_o
);

    fq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue between IFU and decode: small FIFO of {pc, instr} with flush.
// Optional build macro FETCH_QUEUE_BYPASS_EN adds a zero-latency path when empty.
module fetch_queue
    import fq_pkg::*;
#(
    parameter int          DEPTH = FQ_DEPTH,
    parameter logic [31:0] NOP   = FQ_NOP
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_pc,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    fq_entry_t in_entry;
    fq_entry_t head_entry;
    logic      empty;
    logic      byp_active;
    logic      push;
    logic      pop;
    logic      mem_we;
    logic      mem_pop;

    assign in_entry = '{pc: in_pc, instr: in_instr};
    assign empty    = (count_q == '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign byp_active = empty & in_valid & ~flush;
`else
    assign byp_active = 1'b0;
`endif

    // Readiness is purely a function of occupancy, so a full queue never
    // accepts on the strength of a same-cycle pop.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = ~empty | byp_active;

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // A bypassed entry that decode takes immediately never touches storage.
    assign mem_we  = push & ~(byp_active & out_ready);
    assign mem_pop = pop & ~empty;

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_mem (
        .clk     (clk),
        .we_i    (mem_we),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_entry),
        .raddr_i (rd_ptr_q),
        .rdata_o (head_entry)
    );

    always_comb begin
        out_pc    = 32'h0;
        out_instr = NOP;
        if (!empty) begin
            out_pc    = head_entry.pc;
            out_instr = head_entry.instr;
        end else if (byp_active) begin
            out_pc    = in_entry.pc;
            out_instr = in_entry.instr;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (mem_we) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (mem_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({mem_we, mem_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus random traffic
// checked against a queue-based reference model.
module tb_fetch_queue;

    localparam int          DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = 32'h0;
    logic [31:0] in_instr = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;
    ent_t mq[$];

    fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_instr (out_instr),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Reference model: what decode should see given the queued entries.
    function automatic bit m_byp();
        return BYP && (mq.size() == 0) && in_valid && !flush;
    endfunction

    function automatic bit m_valid();
        return (mq.size() != 0) || m_byp();
    endfunction

    function automatic logic [31:0] m_pc();
        if (mq.size() != 0) return mq[0].pc;
        if (m_byp()) return in_pc;
        return 32'h0;
    endfunction

    function automatic logic [31:0] m_instr();
        if (mq.size() != 0) return mq[0].instr;
        if (m_byp()) return in_instr;
        return NOP;
    endfunction

    task automatic drive(input logic r, input logic f, input logic iv,
                         input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
        @(negedge clk);
        reset     = r;
        flush     = f;
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = ins;
        out_ready = ordy;
        #1;
    endtask

    // Advance the model with the inputs currently applied, then take the edge.
    task automatic tick();
        int n;
        bit pu, po;
        n = mq.size();
        if (!reset || flush) begin
            mq.delete();
        end else begin
            pu = in_valid && (n < DEPTH);
            po = m_valid() && out_ready;
            if (!(po && n == 0)) begin
                if (po) void'(mq.pop_front());
                if (pu) mq.push_back('{in_pc, in_instr});
            end
        end
        @(posedge clk);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 32'h0, 32'h0, 0); tick();
        drive(0, 0, 0, 32'h0, 32'h0, 0); tick();
        drive(1, 0, 0, 32'h0, 32'h0, 0);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_instr !== NOP) begin errors++; $display("FAIL reset_instr: got %h want %h", out_instr, NOP); end
        checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want 0", out_pc); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tick();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 32'h3000 + 32'(4 * i), 32'(i + 1), 0);
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b want 1", i, in_ready); end
            checks++; if (count !== 3'(i)) begin errors++; $display("FAIL fill_count%0d: got %0d want %0d", i, count, i); end
            tick();
        end
        drive(1, 0, 1, 32'h3010, 32'd5, 0);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b want 0", in_ready); end
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d want 4", count); end
        checks++; if (out_pc !== 32'h3000 || out_instr !== 32'd1) begin
            errors++; $display("FAIL full_head: got %h/%h want 3000/1", out_pc, out_instr); end
        tick();
        drive(1, 0, 1, 32'h3010, 32'd5, 0);
        checks++; if (count !== 3'd4) begin errors++; $display("FAIL stall_count: got %0d want 4", count); end
        tick();
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            drive(1, 0, 1, 32'h3010 + 32'(4 * i), 32'(5 + i), 1);
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3000 + 32'(4 * i) || out_instr !== 32'(i + 1)) begin
                errors++; $display("FAIL drain_head%0d: got %b %h/%h want 1 %h/%h", i, out_valid, out_pc, out_instr,
                                   32'h3000 + 32'(4 * i), 32'(i + 1)); end
            checks++; if (in_ready !== (i != 0)) begin errors++; $display("FAIL drain_ready%0d: got %b want %b", i, in_ready, i != 0); end
            checks++; if (count !== ((i == 0) ? 3'd4 : 3'd3)) begin
                errors++; $display("FAIL drain_count%0d: got %0d want %0d", i, count, (i == 0) ? 4 : 3); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 1, 0, 32'h0, 32'h0, 0); tick();
        drive(1, 0, 1, 32'h3000, 32'd99, 0); tick();
        for (int i = 0; i < 10; i++) begin
            drive(1, 0, 1, 32'h3004 + 32'(4 * i), 32'(100 + i), 1);
            checks++; if (count !== 3'd1) begin errors++; $display("FAIL b2b_count%0d: got %0d want 1", i, count); end
            checks++; if (out_pc !== 32'h3000 + 32'(4 * i) || out_instr !== 32'(99 + i)) begin
                errors++; $display("FAIL b2b_head%0d: got %h/%h want %h/%h", i, out_pc, out_instr,
                                   32'h3000 + 32'(4 * i), 32'(99 + i)); end
            tick();
        end
    endtask

    task automatic test_flush();
        drive(1, 1, 0, 32'h0, 32'h0, 0); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 1, 32'h3000 + 32'(4 * i), 32'(10 + i), 0); tick();
        end
        drive(1, 1, 1, 32'h300C, 32'd13, 1);
        checks++; if (count !== 3'd3 || out_valid !== 1'b1) begin
            errors++; $display("FAIL preflush: got cnt=%0d v=%b want cnt=3 v=1", count, out_valid); end
        tick();
        drive(1, 0, 0, 32'h0, 32'h0, 0);
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count: got %0d want 0", count); end
        checks++; if (out_valid !== 1'b0 || out_pc !== 32'h0 || out_instr !== NOP) begin
            errors++; $display("FAIL flush_out: got %b %h/%h want 0 0/%h", out_valid, out_pc, out_instr, NOP); end
        tick();
        drive(1, 0, 1, 32'h3020, 32'd77, 0); tick();
        drive(1, 0, 0, 32'h0, 32'h0, 0);
        checks++; if (count !== 3'd1 || out_pc !== 32'h3020 || out_instr !== 32'd77) begin
            errors++; $display("FAIL postflush: got cnt=%0d %h/%h want 1 3020/77", count, out_pc, out_instr); end
        tick();
    endtask

    task automatic test_bypass();
        drive(1, 1, 0, 32'h0, 32'h0, 0); tick();
        drive(1, 0, 1, 32'h3010, 32'h24080001, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3010 || out_instr !== 32'h24080001) begin
            errors++; $display("FAIL byp_same: got %b %h/%h want 1 3010/24080001", out_valid, out_pc, out_instr); end
        tick();
        drive(1, 0, 0, 32'h0, 32'h0, 0);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL byp_after: got cnt=%0d v=%b want 0 0", count, out_valid); end
        tick();
`else
        checks++; if (out_valid !== 1'b0 || out_instr !== NOP) begin
            errors++; $display("FAIL nobyp_same: got %b %h want 0 %h", out_valid, out_instr, NOP); end
        tick();
        drive(1, 0, 0, 32'h0, 32'h0, 1);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h3010 || count !== 3'd1) begin
            errors++; $display("FAIL nobyp_next: got %b %h cnt=%0d want 1 3010 1", out_valid, out_pc, count); end
        tick();
`endif
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 1, 32'h3040, 32'd1, 0); tick();
        drive(1, 0, 1, 32'h3044, 32'd2, 0); tick();
        drive(0, 1, 1, 32'h3048, 32'd3, 1); tick();
        drive(1, 0, 0, 32'h0, 32'h0, 0);
        checks++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid: got cnt=%0d v=%b r=%b want 0 0 1", count, out_valid, in_ready); end
        tick();
    endtask

    task automatic test_random();
        int seq;
        logic r, f, iv, ordy;
        seq = 0;
        for (int c = 0; c < 400; c++) begin
            r    = ($urandom_range(0, 49) != 0);
            f    = ($urandom_range(0, 19) == 0);
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            drive(r, f, iv, 32'h3000 + 32'(4 * seq), $urandom, ordy);
            seq++;
            checks++; if (out_valid !== m_valid()) begin
                errors++; $display("FAIL rand_valid c%0d: got %b want %b", c, out_valid, m_valid()); end
            checks++; if (out_pc !== m_pc() || out_instr !== m_instr()) begin
                errors++; $display("FAIL rand_data c%0d: got %h/%h want %h/%h", c, out_pc, out_instr, m_pc(), m_instr()); end
            checks++; if (count !== 3'(mq.size()) || in_ready !== (mq.size() < DEPTH)) begin
                errors++; $display("FAIL rand_occ c%0d: got cnt=%0d r=%b want cnt=%0d r=%b", c, count, in_ready,
                                   mq.size(), mq.size() < DEPTH); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_bypass();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
